// File: rtl/regfile_wr_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wr_pkg
// Shared constants and types for the register-file write-port arbiter.
//   DATA_W      : write data width
//   ADDR_W      : register address width (16-entry register file)
//   ZERO_REG    : hardwired-zero register; writes to it are accepted and dropped
//   wr_src_t    : identifies which requester produced the current write
//   pri_state_t : round-robin priority owner
// ---------------------------------------------------------------------------
package regfile_wr_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] ZERO_REG = 4'd15;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wr_src_t;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_state_t;

endpackage

// File: rtl/en_decode4_16.sv
// ---------------------------------------------------------------------------
// en_decode4_16
// 4-to-16 one-hot decoder with enable. Output is all zero when en is low.
//   addr [3:0]  : index to decode
//   en          : decode enable
//   dec  [15:0] : one-hot result
// ---------------------------------------------------------------------------
module en_decode4_16 (
    input  logic [3:0]  addr,
    input  logic        en,
    output logic [15:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the memory-load writeback path using round-robin arbitration. The
// winning request is registered and decoded into a one-hot write enable the
// following cycle (latency 1, no bubble between back-to-back grants).
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. ready is combinational, never high without its own valid, and low
// while reset or rf_stall is asserted. A requester that sees ready low must
// hold addr/data stable until it is accepted; nothing is buffered here.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rf_stall            : register file cannot take a write; no grants issued
//   alu_valid/addr/data : ALU writeback request, alu_ready = accepted
//   mem_valid/addr/data : load writeback request, mem_ready = accepted
//   wr_en   [15:0]      : one-hot write enable, zero when idle
//   wr_data             : registered write data
//   wr_src              : source of current write (0 = ALU, 1 = MEM)
//   pri_state           : current priority owner (observability)
//   conflict_cnt [15:0] : only with REGFILE_WR_CONFLICT_CNT_EN defined;
//                         saturating count of unstalled cycles where both
//                         requesters were valid
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int                                  DATA_W   = regfile_wr_pkg::DATA_W,
    parameter logic [regfile_wr_pkg::ADDR_W-1:0]   ZERO_REG = regfile_wr_pkg::ZERO_REG
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rf_stall,
    input  logic                                alu_valid,
    input  logic [regfile_wr_pkg::ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]                   alu_data,
    output logic                                alu_ready,
    input  logic                                mem_valid,
    input  logic [regfile_wr_pkg::ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]                   mem_data,
    output logic                                mem_ready,
    output logic [15:0]                         wr_en,
    output logic [DATA_W-1:0]                   wr_data,
    output logic                                wr_src,
    output regfile_wr_pkg::pri_state_t          pri_state
`ifdef REGFILE_WR_CONFLICT_CNT_EN
    ,
    output logic [15:0]                         conflict_cnt
`endif
);

    import regfile_wr_pkg::*;

    pri_state_t            state_q;
    pri_state_t            state_d;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  any_grant;
    logic [ADDR_W-1:0]     grant_addr;
    logic [DATA_W-1:0]     grant_data;

    logic                  valid_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    wr_src_t               src_q;

    // Grants: a lone requester always wins; on a conflict the priority owner
    // wins. Reset and rf_stall block every grant.
    always_comb begin
        alu_grant  = 1'b0;
        mem_grant  = 1'b0;
        if (!reset && !rf_stall) begin
            alu_grant = alu_valid && (!mem_valid || (state_q == PRI_ALU));
            mem_grant = mem_valid && (!alu_valid || (state_q == PRI_MEM));
        end
        any_grant  = alu_grant || mem_grant;
        grant_addr = alu_grant ? alu_addr : mem_addr;
        grant_data = alu_grant ? alu_data : mem_data;
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Priority FSM: the side just served loses priority; no grant, no change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRI_ALU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (alu_grant) begin
            state_d = PRI_MEM;
        end else if (mem_grant) begin
            state_d = PRI_ALU;
        end
    end

    assign pri_state = state_q;

    // Output stage. A write to ZERO_REG is accepted and still updates
    // wr_data/wr_src, but never raises a write enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            src_q   <= SRC_ALU;
        end else begin
            valid_q <= any_grant && (grant_addr != ZERO_REG);
            if (any_grant) begin
                addr_q <= grant_addr;
                data_q <= grant_data;
                src_q  <= alu_grant ? SRC_ALU : SRC_MEM;
            end
        end
    end

    en_decode4_16 u_wr_decode (
        .addr (addr_q),
        .en   (valid_q),
        .dec  (wr_en)
    );

    assign wr_data = data_q;
    assign wr_src  = src_q;

`ifdef REGFILE_WR_CONFLICT_CNT_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (alu_valid && mem_valid && !rf_stall && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed scenarios for regfile_wr_arbiter with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; combinational readys are
// checked 1 unit later, registered outputs 1 unit after the following edge.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    import regfile_wr_pkg::*;

    logic              clk;
    logic              reset;
    logic              rf_stall;
    logic              alu_valid;
    logic [3:0]        alu_addr;
    logic [63:0]       alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [3:0]        mem_addr;
    logic [63:0]       mem_data;
    logic              mem_ready;
    logic [15:0]       wr_en;
    logic [63:0]       wr_data;
    logic              wr_src;
    pri_state_t        pri_state;
`ifdef REGFILE_WR_CONFLICT_CNT_EN
    logic [15:0]       conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .rf_stall  (rf_stall),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .pri_state (pri_state)
`ifdef REGFILE_WR_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rf_stall  = 1'b0;
        alu_addr  = '0;
        mem_addr  = '0;
        alu_data  = '0;
        mem_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b1;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        tick();
        tick();
        n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        n_checks++; if (wr_en !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_en: got %h want 0000", wr_en); end
        n_checks++; if (wr_data !== 64'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_checks++; if (wr_src !== 1'b0) begin n_fail++; $display("FAIL reset_wr_src: got %b want 0", wr_src); end
        n_checks++; if (pri_state !== PRI_ALU) begin n_fail++; $display("FAIL reset_pri: got %0d want PRI_ALU", pri_state); end
`ifdef REGFILE_WR_CONFLICT_CNT_EN
        n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
`endif
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 64'hA5;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL single_mem_ready: got %b want 0", mem_ready); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if (wr_en !== 16'h0008) begin n_fail++; $display("FAIL single_wr_en: got %h want 0008", wr_en); end
        n_checks++; if (wr_data !== 64'hA5) begin n_fail++; $display("FAIL single_wr_data: got %h want a5", wr_data); end
        n_checks++; if (wr_src !== 1'b0) begin n_fail++; $display("FAIL single_wr_src: got %b want 0", wr_src); end
        n_checks++; if (pri_state !== PRI_MEM) begin n_fail++; $display("FAIL single_pri: got %0d want PRI_MEM", pri_state); end
        tick();
        n_checks++; if (wr_en !== 16'h0000) begin n_fail++; $display("FAIL single_idle_wr_en: got %h want 0000", wr_en); end
        n_checks++; if (wr_data !== 64'hA5) begin n_fail++; $display("FAIL single_hold_data: got %h want a5", wr_data); end
    endtask

    task automatic test_conflict_pair();
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 64'h22;
        #1;
        n_checks++; if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL pair_c0_ready: got %b want 10", {alu_ready, mem_ready}); end
        tick();
        n_checks++; if (wr_en !== 16'h0002) begin n_fail++; $display("FAIL pair_c1_wr_en: got %h want 0002", wr_en); end
        n_checks++; if ({alu_ready, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL pair_c1_ready: got %b want 01", {alu_ready, mem_ready}); end
        tick();
        idle_inputs();
        n_checks++; if (wr_en !== 16'h0004) begin n_fail++; $display("FAIL pair_c2_wr_en: got %h want 0004", wr_en); end
        n_checks++; if (wr_data !== 64'h22) begin n_fail++; $display("FAIL pair_c2_wr_data: got %h want 22", wr_data); end
        n_checks++; if (wr_src !== 1'b1) begin n_fail++; $display("FAIL pair_c2_wr_src: got %b want 1", wr_src); end
    endtask

    task automatic test_back_to_back();
        logic        exp_alu;
        logic [15:0] exp_en;
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 64'h55;
        mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 64'h66;
        for (int i = 0; i < 6; i++) begin
            exp_alu = (i % 2 == 0);
            exp_en  = exp_alu ? 16'h0020 : 16'h0040;
            #1;
            n_checks++; if ({alu_ready, mem_ready} !== {exp_alu, ~exp_alu}) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, {alu_ready, mem_ready}, {exp_alu, ~exp_alu}); end
            tick();
            if (i == 5) idle_inputs();
            n_checks++; if (wr_en !== exp_en) begin n_fail++; $display("FAIL b2b_wr_en[%0d]: got %h want %h", i, wr_en, exp_en); end
            n_checks++; if (wr_src !== ~exp_alu) begin n_fail++; $display("FAIL b2b_wr_src[%0d]: got %b want %b", i, wr_src, ~exp_alu); end
        end
`ifdef REGFILE_WR_CONFLICT_CNT_EN
        n_checks++; if (conflict_cnt !== 16'd6) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 6", conflict_cnt); end
`endif
    endtask

    task automatic test_zero_reg();
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd15; alu_data = 64'h77;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_alu_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if (wr_en !== 16'h0000) begin n_fail++; $display("FAIL zero_alu_wr_en: got %h want 0000", wr_en); end
        n_checks++; if (wr_data !== 64'h77) begin n_fail++; $display("FAIL zero_alu_wr_data: got %h want 77", wr_data); end
        n_checks++; if (pri_state !== PRI_MEM) begin n_fail++; $display("FAIL zero_alu_pri: got %0d want PRI_MEM", pri_state); end
        mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 64'hFF;
        #1;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL zero_mem_ready: got %b want 1", mem_ready); end
        tick();
        mem_valid = 1'b0;
        n_checks++; if (wr_en !== 16'h0000) begin n_fail++; $display("FAIL zero_mem_wr_en: got %h want 0000", wr_en); end
        n_checks++; if (wr_src !== 1'b1) begin n_fail++; $display("FAIL zero_mem_wr_src: got %b want 1", wr_src); end
        n_checks++; if (wr_data !== 64'hFF) begin n_fail++; $display("FAIL zero_mem_wr_data: got %h want ff", wr_data); end
        n_checks++; if (pri_state !== PRI_ALU) begin n_fail++; $display("FAIL zero_mem_pri: got %0d want PRI_ALU", pri_state); end
    endtask

    task automatic test_stall();
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 64'h44;
        tick();
        // Grant of addr 4 is in flight; stall with both requesters pending.
        rf_stall  = 1'b1;
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 64'h22;
        #1;
        n_checks++; if (wr_en !== 16'h0010) begin n_fail++; $display("FAIL stall_inflight_wr_en: got %h want 0010", wr_en); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({alu_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {alu_ready, mem_ready}); end
            tick();
            n_checks++; if (wr_en !== 16'h0000) begin n_fail++; $display("FAIL stall_wr_en[%0d]: got %h want 0000", i, wr_en); end
        end
        n_checks++; if (pri_state !== PRI_MEM) begin n_fail++; $display("FAIL stall_pri: got %0d want PRI_MEM", pri_state); end
        rf_stall = 1'b0;
        #1;
        n_checks++; if ({alu_ready, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_release_ready: got %b want 01", {alu_ready, mem_ready}); end
        tick();
        idle_inputs();
        n_checks++; if (wr_en !== 16'h0004) begin n_fail++; $display("FAIL stall_release_wr_en: got %h want 0004", wr_en); end
        n_checks++; if (wr_src !== 1'b1) begin n_fail++; $display("FAIL stall_release_src: got %b want 1", wr_src); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 64'h22;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if ({alu_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL midrst_ready: got %b want 00", {alu_ready, mem_ready}); end
        tick();
        reset = 1'b0;
        n_checks++; if (wr_en !== 16'h0000) begin n_fail++; $display("FAIL midrst_wr_en: got %h want 0000", wr_en); end
        n_checks++; if (wr_data !== 64'h0) begin n_fail++; $display("FAIL midrst_wr_data: got %h want 0", wr_data); end
        n_checks++; if (pri_state !== PRI_ALU) begin n_fail++; $display("FAIL midrst_pri: got %0d want PRI_ALU", pri_state); end
        #1;
        n_checks++; if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL midrst_regrant: got %b want 10", {alu_ready, mem_ready}); end
        tick();
        idle_inputs();
        n_checks++; if (wr_en !== 16'h0002) begin n_fail++; $display("FAIL midrst_wr_en2: got %h want 0002", wr_en); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_conflict_pair();
        test_back_to_back();
        test_zero_reg();
        test_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: the ALU result path and the memory-load path. Arbitration is round-robin. The winning address is registered and driven through the existing en_decode4_16 decoder, which produces the one-hot 16-bit write enable. The block sits between the execute/memory writeback stages and the register file.

Parameters:
DATA_W, 64, width of write data.
ADDR_W, 4, register address width; fixed at 4 to match the 16-entry register file.
ZERO_REG, 4'd15, address whose writes are accepted but discarded (hardwired-zero register).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
rf_stall  in  1  register file cannot accept a write this cycle; no grants are issued.
alu_valid  in  1  ALU writeback request.
alu_addr  in  ADDR_W  ALU destination register.
alu_data  in  DATA_W  ALU result.
alu_ready  out  1  ALU request accepted this cycle (combinational).
mem_valid  in  1  load writeback request.
mem_addr  in  ADDR_W  load destination register.
mem_data  in  DATA_W  load data.
mem_ready  out  1  load request accepted this cycle (combinational).
wr_en  out  16  one-hot register write enable; all zero when idle.
wr_data  out  DATA_W  registered write data.
wr_src  out  1  source of the current write: 0 = ALU, 1 = MEM.

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both high.
  - ready is never asserted without the matching valid.
  - Requesters hold addr/data stable while valid is high and ready is low.
- Grant logic (combinational):
  - rf_stall = 1: both readys are 0.
  - Only one requester valid: that requester gets ready = 1.
  - Both valid: the priority owner gets ready = 1; the other gets ready = 0.
- Priority FSM, two states:
  - PRI_ALU: ALU wins a conflict.
  - PRI_MEM: MEM wins a conflict.
  - After any ALU grant the next state is PRI_MEM; after any MEM grant it is PRI_ALU.
  - No grant: state holds.
  - Reset state is PRI_ALU.
- Output stage (latency 1):
  - On a grant, the granted addr/data/src are registered together with a valid bit.
  - The next cycle, wr_en is driven by en_decode4_16(addr_q, valid_q) and wr_data = data_q.
  - No grant: valid_q = 0, so wr_en = 16'h0000; wr_data and wr_src hold their last values.
  - Back-to-back grants produce writes on consecutive cycles. There is no bubble.
- ZERO_REG:
  - The request is granted normally (ready = 1, FSM advances).
  - valid_q is forced to 0, so wr_en = 0.
  - wr_src and wr_data still update.
- Same address from both requesters: no special handling. Each is written in its own cycle in grant order.
- rf_stall asserted:
  - No new grants.
  - A write already registered still completes on its cycle.
  - The FSM holds.
- Reset (including mid-operation):
  - wr_en = 0, wr_data = 0, wr_src = 0, valid_q = 0, FSM = PRI_ALU, optional counter = 0.
  - readys are 0 during reset.
- No internal request buffering: a losing requester simply stalls.

Optional Feature:
REGFILE_WR_CONFLICT_CNT_EN
- Defined:
  - Adds output port conflict_cnt [15:0].
  - The counter increments each cycle that both alu_valid and mem_valid are high and rf_stall = 0.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined: the port and the counter are absent. Arbitration is identical.

Decomposition:
- Package regfile_wr_pkg contains:
  - DATA_W and ADDR_W constants.
  - ZERO_REG constant.
  - typedef enum logic {SRC_ALU = 0, SRC_MEM = 1} wr_src_t.
  - typedef enum logic {PRI_ALU, PRI_MEM} pri_state_t.
- The single sub-module is the existing en_decode4_16, instantiated once for the wr_en decode. Grant logic and the FSM stay inline.

Test Plan:
1. Reset, then alu_valid = 1, alu_addr = 3, alu_data = 64'hA5 → alu_ready = 1 same cycle; next cycle wr_en = 16'h0008, wr_data = 64'hA5, wr_src = 0.
2. Both valid after reset (ALU addr 1, MEM addr 2) held for 2 cycles → cycle 0 ALU granted, cycle 1 MEM granted; wr_en sequence 16'h0002 then 16'h0004.
3. Both valid continuously for 6 cycles → grants alternate ALU, MEM, ALU, MEM, ALU, MEM; conflict_cnt = 6 with the macro defined.
4. mem_valid = 1, addr = 15, data = 64'hFF → mem_ready = 1; next cycle wr_en = 16'h0000, wr_src = 1.
5. rf_stall = 1 for 3 cycles with both valid → both readys 0 and wr_en = 0 after the in-flight write; on release, the owner stored before the stall is granted first.
6. Assert reset in the cycle after a grant → wr_en = 0 next cycle, FSM = PRI_ALU; a subsequent conflict grants ALU.
